bist_session_controller: RTL and testbench

Parametrised BIST sequencer; successor to the single-run controller.
- Runs NSESSIONS back-to-back test sessions per start, each of NCLOCK running cycles.
- Emits init/running/toggle/finish strobes per session and the current session index.
- Accumulates a pass verdict from a per-session signature-compare input and holds bist_end plus the verdict until restarted or reset.
- Sits between the top-level test-mode logic and the pattern generator / signature analyser.

---
 rtl/bist_session_controller.sv | 104 ++++++++++
 tb/tb_bist_session_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bist_session_controller.sv
// bist_session_controller: multi-session BIST sequencer with init/run/toggle/finish strobes and pass verdict.
// Optional abort input and aborted flag are built in when BIST_ABORT_EN is defined.
module bist_session_controller #(
    parameter int NCLOCK = 650,
    parameter int NSESSIONS = 4,
    parameter int TOGGLE_PERIOD = 2,
    localparam int SW = (NSESSIONS > 1) ? $clog2(NSESSIONS) : 1,
    localparam int CW = (NCLOCK > 1) ? $clog2(NCLOCK) : 1,
    localparam int TW = $clog2(TOGGLE_PERIOD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          sig_ok,
`ifdef BIST_ABORT_EN
    input  logic          abort,
    output logic          aborted,
`endif
    output logic          init,
    output logic          running,
    output logic          toggle,
    output logic          finish,
    output logic [SW-1:0] session,
    output logic          bist_end,
    output logic          pass
);
    typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_FINISH, S_END} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] run_cnt_q, run_cnt_d;
    logic [TW-1:0] tog_cnt_q, tog_cnt_d;
    logic [SW-1:0] session_q, session_d;
    logic          pass_acc_q, pass_acc_d;
    logic          init_q, init_d, running_q, running_d, toggle_q, toggle_d;
    logic          finish_q, finish_d, bist_end_q, bist_end_d, pass_q, pass_d;
    logic          active, new_run, stay_run, kill;
    assign active   = state_q inside {S_INIT, S_RUN, S_FINISH};
    assign new_run  = (state_q == S_IDLE || state_q == S_END) && start;
    assign stay_run = state_q == S_RUN && state_d == S_RUN;
`ifdef BIST_ABORT_EN
    logic aborted_q, aborted_d;
    assign kill = active && abort;
    assign aborted_d = new_run ? 1'b0 : kill ? 1'b1 : aborted_q;
    always_ff @(posedge clk) aborted_q <= reset ? 1'b0 : aborted_d;
    assign aborted = aborted_q;
`else
    assign kill = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_END: if (start) state_d = S_INIT;
            S_INIT:        state_d = S_RUN;
            S_RUN:         if (run_cnt_q == CW'(NCLOCK - 1)) state_d = S_FINISH;
            S_FINISH:      state_d = (session_q == SW'(NSESSIONS - 1)) ? S_END : S_INIT;
            default:       state_d = S_IDLE;
        endcase
        if (kill) state_d = S_END;
        run_cnt_d  = stay_run ? run_cnt_q + CW'(1) : '0;
        tog_cnt_d  = !stay_run ? '0 : (tog_cnt_q == TW'(TOGGLE_PERIOD - 1)) ? '0 : tog_cnt_q + TW'(1);
        session_d  = new_run ? '0 : (state_q == S_FINISH && state_d == S_INIT) ? session_q + SW'(1) : session_q;
        pass_acc_d = new_run ? 1'b1 : kill ? 1'b0 : (state_q == S_FINISH) ? pass_acc_q & sig_ok : pass_acc_q;
        // strobes are decoded from the next state so they line up with the state they describe
        init_d     = state_d == S_INIT;
        running_d  = state_d == S_RUN;
        toggle_d   = state_d == S_RUN && tog_cnt_d == TW'(TOGGLE_PERIOD - 1);
        finish_d   = state_d == S_FINISH;
        bist_end_d = state_q == S_END;
        pass_d     = state_q == S_END && pass_acc_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            run_cnt_q  <= '0;
            tog_cnt_q  <= '0;
            session_q  <= '0;
            pass_acc_q <= 1'b0;
            init_q     <= 1'b0;
            running_q  <= 1'b0;
            toggle_q   <= 1'b0;
            finish_q   <= 1'b0;
            bist_end_q <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_cnt_q  <= run_cnt_d;
            tog_cnt_q  <= tog_cnt_d;
            session_q  <= session_d;
            pass_acc_q <= pass_acc_d;
            init_q     <= init_d;
            running_q  <= running_d;
            toggle_q   <= toggle_d;
            finish_q   <= finish_d;
            bist_end_q <= bist_end_d;
            pass_q     <= pass_d;
        end
    end
    assign init     = init_q;
    assign running  = running_q;
    assign toggle   = toggle_q;
    assign finish   = finish_q;
    assign session  = session_q;
    assign bist_end = bist_end_q;
    assign pass     = pass_q;
endmodule

// File: tb/tb_bist_session_controller.sv
// tb_bist_session_controller: directed checks of a small (8,2,2) instance and a default instance.
module tb_bist_session_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       reset, start, sig_ok, init, running, toggle, finish, bist_end, pass;
    logic [0:0] session;
    logic       reset_b, start_b, sig_ok_b, init_b, running_b, toggle_b, finish_b, bist_end_b, pass_b;
    logic [1:0] session_b;
`ifdef BIST_ABORT_EN
    logic aborted_a, aborted_b;
`endif
    bist_session_controller #(.NCLOCK(8), .NSESSIONS(2), .TOGGLE_PERIOD(2)) dut (
        .clk(clk), .reset(reset), .start(start), .sig_ok(sig_ok),
`ifdef BIST_ABORT_EN
        .abort(1'b0), .aborted(aborted_a),
`endif
        .init(init), .running(running), .toggle(toggle), .finish(finish),
        .session(session), .bist_end(bist_end), .pass(pass)
    );
    bist_session_controller dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .sig_ok(sig_ok_b),
`ifdef BIST_ABORT_EN
        .abort(1'b0), .aborted(aborted_b),
`endif
        .init(init_b), .running(running_b), .toggle(toggle_b), .finish(finish_b),
        .session(session_b), .bist_end(bist_end_b), .pass(pass_b)
    );
    int nt = 0, nf = 0, cyc = 0, e0 = 0, rise, rb;
    int ci = 0, cr = 0, ct = 0, cf = 0, cbe = 0, xa = 0;
    int bi = 0, br = 0, bt = 0, bf = 0, xb = 0;
    logic clr = 1'b0;
    always @(posedge clk) begin
        if (clr) begin
            ci <= 0; cr <= 0; ct <= 0; cf <= 0; cbe <= 0;
        end else begin
            ci  <= ci + int'(init);
            cr  <= cr + int'(running);
            ct  <= ct + int'(toggle);
            cf  <= cf + int'(finish);
            cbe <= cbe + int'(bist_end);
        end
        if (int'(init) + int'(running) + int'(finish) > 1 || (toggle && !running)) xa <= xa + 1;
    end
    always @(posedge clk) begin
        bi <= bi + int'(init_b);
        br <= br + int'(running_b);
        bt <= bt + int'(toggle_b);
        bf <= bf + int'(finish_b);
        if (int'(init_b) + int'(running_b) + int'(finish_b) > 1 || (toggle_b && !running_b)) xb <= xb + 1;
    end
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nt++;
        assert (obs === exp) else begin
            nf++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask
    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
        e0 = cyc;
    endtask
    task automatic wait_end(input int maxc, output int r);
        r = -1;
        for (int j = 0; j < maxc && r < 0; j++) begin
            tick();
            if (bist_end === 1'b1) r = cyc - e0;
        end
    endtask
    task automatic chk_zero(input string s);
        chk({s, "_init"}, init, 0);
        chk({s, "_running"}, running, 0);
        chk({s, "_toggle"}, toggle, 0);
        chk({s, "_finish"}, finish, 0);
        chk({s, "_session"}, session, 0);
        chk({s, "_bist_end"}, bist_end, 0);
        chk({s, "_pass"}, pass, 0);
    endtask
    task automatic chk_run(input string s, input int r, input logic p);
        chk({s, "_rise"}, r, 21);
        chk({s, "_inits"}, ci, 2);
        chk({s, "_running"}, cr, 16);
        chk({s, "_toggles"}, ct, 8);
        chk({s, "_finishes"}, cf, 2);
        chk({s, "_bist_end"}, bist_end, 1);
        chk({s, "_pass"}, pass, p);
        chk({s, "_session"}, session, 1);
    endtask
    initial begin
        reset = 1'b1; start = 1'b0; sig_ok = 1'b1;
        reset_b = 1'b1; start_b = 1'b0; sig_ok_b = 1'b1;
        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b0;
        clear();
        tick();
        chk("idle_init", init, 0);
        // basic run from IDLE
        go();
        chk("s1_e0_init", init, 1);
        chk("s1_e0_session", session, 0);
        tick();
        chk("s1_e1_running", running, 1);
        chk("s1_e1_init", init, 0);
        wait_end(40, rise);
        chk_run("s1", rise, 1'b1);
        repeat (5) tick();
        chk("s1_hold_end", bist_end, 1);
        chk("s1_hold_pass", pass, 1);
        chk("s1_hold_inits", ci, 2);
        // restart from END; session 0 signature mismatch
        clear();
        go();
        chk("s3_e0_init", init, 1);
        chk("s3_e0_session", session, 0);
        tick();
        chk("s3_e1_bist_end", bist_end, 0);
        chk("s3_e1_pass", pass, 0);
        repeat (8) tick();
        chk("s3_e9_finish", finish, 1);
        sig_ok = 1'b0;
        tick();
        sig_ok = 1'b1;
        chk("s3_e10_session", session, 1);
        chk("s3_e10_init", init, 1);
        wait_end(40, rise);
        chk_run("s3", rise, 1'b0);
        // start re-pulsed 3 cycles into RUN
        clear();
        go();
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_end(40, rise);
        chk_run("s4", rise, 1'b1);
        // reset and start together, then start alone
        reset = 1'b1; start = 1'b1;
        tick();
        chk_zero("s5_r1");
        tick();
        chk_zero("s5_r2");
        reset = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0; start = 1'b0; e0 = cyc;
        chk("s5_e0_init", init, 1);
        wait_end(40, rise);
        chk_run("s5", rise, 1'b1);
        // reset 5 cycles into session 1 RUN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear();
        go();
        repeat (16) tick();
        chk("s6_e16_running", running, 1);
        chk("s6_e16_session", session, 1);
        reset = 1'b1;
        tick();
        chk_zero("s6_abort");
        reset = 1'b0;
        repeat (30) tick();
        chk("s6_inits", ci, 2);
        chk("s6_finishes", cf, 1);
        chk("s6_toggles", ct, 7);
        chk("s6_running", cr, 14);
        chk("s6_bist_end_cycles", cbe, 0);
        chk_zero("s6_idle");
        clear();
        go();
        wait_end(40, rise);
        chk_run("s6_clean", rise, 1'b1);
        // default parameters
        reset_b = 1'b0;
        tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        e0 = cyc;
        chk("def_e0_init", init_b, 1);
        rb = -1;
        for (int j = 0; j < 3000 && rb < 0; j++) begin
            tick();
            if (bist_end_b === 1'b1) rb = cyc - e0;
        end
        chk("def_rise", rb, 2609);
        chk("def_toggles", bt, 1300);
        chk("def_running", br, 2600);
        chk("def_inits", bi, 4);
        chk("def_finishes", bf, 4);
        chk("def_pass", pass_b, 1);
        chk("def_session", session_b, 3);
        chk("def_bist_end", bist_end_b, 1);
        chk("excl_a", xa, 0);
        chk("excl_b", xb, 0);
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end
endmodule
